int_to_float_rne: RTL

Parametrised successor to the team's 16-bit integer-to-float converter. Converts an INT_WIDTH-bit integer to IEEE-754 single precision. Each transaction selects signed or unsigned interpretation, and results use round-to-nearest-even instead of truncation. Sits between oscillator/envelope integer datapaths and the float DSP chain, with valid/ready handshakes on both sides so it can be stalled by downstream float units.

---
 rtl/int_to_float_rne.sv | 79 +++++++
 1 files changed

// File: rtl/int_to_float_rne.sv
// int_to_float_rne: INT_WIDTH-bit signed/unsigned integer to IEEE-754 single, round-to-nearest-even
//   clk, reset_n (async active-low)
//   in_valid/in_ready/intin/signed_mode : operand handshake, accepted only in IDLE
//   out_valid/out_ready/floatout        : result handshake, floatout held until accepted
module int_to_float_rne #(
   parameter int INT_WIDTH      = 16,
   parameter int SIGNED_DEFAULT = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INT_WIDTH-1:0] intin,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          floatout
);
   if (INT_WIDTH < 2 || INT_WIDTH > 32 || SIGNED_DEFAULT < 0 || SIGNED_DEFAULT > 1) begin : g_bad_param
      $error("int_to_float_rne: illegal parameter value");
   end
   typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
   state_t state, state_d;
   logic                 sign;
   logic [INT_WIDTH-1:0] mag, norm;
   logic [7:0]           exp, exp_n;
   logic [5:0]           msb;
   logic [63:0]          al;
   logic [23:0]          sum;
   logic                 neg, inc;
   assign in_ready  = state == IDLE;
   assign out_valid = state == OUT;
   assign neg       = signed_mode & intin[INT_WIDTH-1];
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = in_valid ? ((intin == '0) ? OUT : NORM) : IDLE;
         NORM:    state_d = ROUND;
         ROUND:   state_d = OUT;
         default: state_d = out_ready ? IDLE : OUT;
      endcase
   end
   always_comb begin
      msb = '0;
      for (int i = 0; i < INT_WIDTH; i++) if (mag[i]) msb = 6'(i);
   end
   assign norm  = mag << (6'(INT_WIDTH - 1) - msb);
   assign exp_n = 8'd127 + {2'b00, msb};
   // Left-align the normalised value in 64 bits and drop the hidden 1: the top 23 bits are the
   // fraction, the next is guard, the rest sticky. Narrow inputs leave guard/sticky at zero.
   assign al  = {mag, {(64 - INT_WIDTH){1'b0}}} << 1;
   assign inc = al[40] & ((|al[39:0]) | al[41]);
   assign sum = {1'b0, al[63:41]} + {23'd0, inc};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         sign     <= 1'b0;
         mag      <= '0;
         exp      <= '0;
         floatout <= '0;
      end else begin
         state <= state_d;
         case (state)
            IDLE: if (in_valid) begin
               sign <= neg;
               mag  <= neg ? -intin : intin;
               if (intin == '0) floatout <= '0;
            end
            NORM: begin
               mag <= norm;
               exp <= exp_n;
            end
            // A carry out of the fraction leaves sum[22:0] at zero, so only the exponent bumps.
            ROUND:   floatout <= {sign, exp + {7'd0, sum[23]}, sum[22:0]};
            default: ;
         endcase
      end
   end
endmodule
